// File: rtl/run_pattern_tx.sv
// Serial run-length pattern transmitter: queued {bit, len} commands become back-to-back runs on `out`.
// Define RUN_TX_GUARD_EN to append one opposite-polarity guard bit after every non-zero run.
module run_pattern_tx #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             nRESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_bit,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

`ifdef RUN_TX_GUARD_EN
  typedef enum logic [1:0] {IDLE, RUN, GUARD} TxState;
`else
  typedef enum logic [1:0] {IDLE, RUN} TxState;
`endif

  logic             bitMem [DEPTH];
  logic [LEN_W-1:0] lenMem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [PTR_W:0]   count;
  logic             push, pop, fetch;
  logic             headBit;
  logic [LEN_W-1:0] headLen;

  TxState           state, stateNext;
  logic [LEN_W-1:0] remaining, remNext;
  logic             curBit, curBitNext;
  logic             outNext, outValidNext, doneNext;

  // cmd_ready is gated by reset so nothing is accepted while nRESET is low.
  assign cmd_ready = nRESET && (count != FULL_COUNT);
  assign push      = cmd_valid && cmd_ready;
  assign headBit   = bitMem[rdPtr];
  assign headLen   = lenMem[rdPtr];
  assign busy      = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      bitMem[wrPtr] <= cmd_bit;
      lenMem[wrPtr] <= cmd_len;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (!push && pop) count <= count - (PTR_W+1)'(1);
    end
  end

  // Outputs are registered from next-state values, so a popped run shows its first bit right after the pop edge.
  always_comb begin
    stateNext    = state;
    remNext      = remaining;
    curBitNext   = curBit;
    outNext      = 1'b0;
    outValidNext = 1'b0;
    doneNext     = 1'b0;
    pop          = 1'b0;
    fetch        = 1'b0;
    case (state)
      IDLE: fetch = 1'b1;
      RUN: begin
        if (remaining != LEN_W'(1)) begin
          remNext      = remaining - LEN_W'(1);
          outNext      = curBit;
          outValidNext = 1'b1;
          doneNext     = (remaining == LEN_W'(2));
        end else begin
`ifdef RUN_TX_GUARD_EN
          stateNext    = GUARD;
          outNext      = ~curBit;
          outValidNext = 1'b1;
`else
          fetch = 1'b1;
`endif
        end
      end
`ifdef RUN_TX_GUARD_EN
      GUARD: fetch = 1'b1;
`endif
      default: stateNext = IDLE;
    endcase
    // Zero-length commands are popped and dropped, leaving one idle cycle.
    if (fetch) begin
      stateNext = IDLE;
      if (count != '0) begin
        pop = 1'b1;
        if (headLen != '0) begin
          stateNext    = RUN;
          remNext      = headLen;
          curBitNext   = headBit;
          outNext      = headBit;
          outValidNext = 1'b1;
          doneNext     = (headLen == LEN_W'(1));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      state     <= IDLE;
      remaining <= '0;
      curBit    <= 1'b0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= stateNext;
      remaining <= remNext;
      curBit    <= curBitNext;
      out       <= outNext;
      out_valid <= outValidNext;
      done      <= doneNext;
    end
  end

endmodule

// File: tb/tb_run_pattern_tx.sv
// Scoreboard bench for run_pattern_tx: accepted commands expand into expected wire bits checked by a monitor.
module tb_run_pattern_tx;

  localparam int DEPTH = 4;
  localparam int LEN_W = 4;
`ifdef RUN_TX_GUARD_EN
  localparam int GUARD_BITS = 1;
`else
  localparam int GUARD_BITS = 0;
`endif

  logic             clk;
  logic             nRESET;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_bit;
  logic [LEN_W-1:0] cmd_len;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  typedef struct packed {logic b; logic d;} ExpBit;
  ExpBit expQ[$];
  int checks = 0;
  int errors = 0;

  run_pattern_tx #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .nRESET(nRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_bit(cmd_bit), .cmd_len(cmd_len), .out(out), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Each accepted command expands into len bits (done on the last) plus an optional guard bit.
  task automatic pushModel(input logic b, input logic [LEN_W-1:0] l);
    for (int i = 0; i < int'(l); i++) expQ.push_back('{b: b, d: (i == int'(l) - 1)});
    if (GUARD_BITS != 0 && l != 0) expQ.push_back('{b: ~b, d: 1'b0});
  endtask

  always @(negedge clk) begin
    ExpBit e;
    if (nRESET === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) pushModel(cmd_bit, cmd_len);
    checks++;
    if (out_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected bit: got out=%b done=%b, expected no valid output", out, done);
      end else begin
        e = expQ.pop_front();
        if (out !== e.b || done !== e.d) begin
          errors++;
          $display("[TB] FAIL scoreboard bit: got out=%b done=%b, expected out=%b done=%b", out, done, e.b, e.d);
        end
      end
    end else if (out_valid !== 1'b0 || done !== 1'b0 || out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle outputs: got valid=%b out=%b done=%b, expected 0 0 0", out_valid, out, done);
    end
    if (nRESET === 1'b0) expQ.delete();
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the command.
  task automatic applyStimulus(input logic b, input logic [LEN_W-1:0] l, output bit stalled);
    int waitCycles = 0;
    cmd_valid = 1'b1;
    cmd_bit   = b;
    cmd_len   = l;
    stalled   = 1'b0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && waitCycles < 500) begin
      stalled = 1'b1;
      waitCycles++;
      @(negedge clk);
    end
    checkOutput("accept within budget", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((busy !== 1'b0 || expQ.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drained", {busy, 31'(expQ.size())}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit st;
    int firstStall;
    int nValid, nOnes, nDone, gaps;
    bit seenValid, endedValid;
    logic [15:0] gotBits, expBits;
    int expLen;
    logic [LEN_W-1:0] rl;

    clk = 1'b0; nRESET = 1'b0; cmd_valid = 1'b1; cmd_bit = 1'b1; cmd_len = 4'd3;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset outputs", {out, out_valid, done, busy}, 32'd0);
      checkOutput("reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    @(posedge clk); #1;
    nRESET = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("ready after reset", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("nothing accepted in reset", {out_valid, busy}, 32'd0);
    end
    @(posedge clk); #1;

    $display("[TB] single run {0,4}");
    applyStimulus(1'b0, 4'd4, st);
    @(negedge clk);
    checkOutput("latency gap", {31'd0, out_valid}, 32'd0);
    for (int k = 1; k <= 4 + GUARD_BITS; k++) begin
      @(negedge clk);
      checkOutput("single run valid", {31'd0, out_valid}, 32'd1);
      checkOutput("single run bit", {31'd0, out}, (k <= 4) ? 32'd0 : 32'd1);
      checkOutput("single run done", {31'd0, done}, (k == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    checkOutput("single run idle after", {out_valid, busy}, 32'd0);
    waitIdle();

    $display("[TB] back-to-back {1,3},{0,2}");
    expBits = '0; expLen = 0;
    for (int i = 0; i < 3; i++) begin expBits[expLen] = 1'b1; expLen++; end
    if (GUARD_BITS != 0) begin expBits[expLen] = 1'b0; expLen++; end
    for (int i = 0; i < 2; i++) begin expBits[expLen] = 1'b0; expLen++; end
    if (GUARD_BITS != 0) begin expBits[expLen] = 1'b1; expLen++; end
    applyStimulus(1'b1, 4'd3, st);
    applyStimulus(1'b0, 4'd2, st);
    nValid = 0; nDone = 0; gaps = 0; seenValid = 0; endedValid = 0; gotBits = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (endedValid) gaps++;
        seenValid = 1'b1;
        if (nValid < 16) gotBits[nValid] = out;
        nValid++;
      end else if (seenValid) endedValid = 1'b1;
      if (done === 1'b1) nDone++;
    end
    checkOutput("b2b length", nValid, expLen);
    checkOutput("b2b gaps", gaps, 32'd0);
    checkOutput("b2b bits", {16'd0, gotBits}, {16'd0, expBits});
    checkOutput("b2b done pulses", nDone, 32'd2);
    waitIdle();

    $display("[TB] zero length {1,0},{1,2}");
    applyStimulus(1'b1, 4'd0, st);
    applyStimulus(1'b1, 4'd2, st);
    nOnes = 0; nDone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && out === 1'b1) nOnes++;
      if (done === 1'b1) nDone++;
    end
    checkOutput("zero-len ones", nOnes, 32'd2);
    checkOutput("zero-len done", nDone, 32'd1);
    waitIdle();

    $display("[TB] FIFO full");
    firstStall = -1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'd15, st);
      if (st && firstStall < 0) firstStall = i;
    end
    checkOutput("first stalled command", firstStall, DEPTH + 1);
    waitIdle();

    $display("[TB] random commands");
    for (int i = 0; i < 40; i++) begin
      rl = LEN_W'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) rl = 4'd15;
      applyStimulus(1'($urandom_range(0, 1)), rl, st);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    waitIdle();

    $display("[TB] mid-run reset");
    applyStimulus(1'b1, 4'd6, st);
    applyStimulus(1'b0, 4'd3, st);
    applyStimulus(1'b1, 4'd2, st);
    nRESET = 1'b0;
    @(negedge clk);
    checkOutput("mid-run bit 2 active", {out_valid, out}, 32'd3);
    @(negedge clk);
    checkOutput("outputs after mid-run reset", {out, out_valid, done, busy}, 32'd0);
    @(posedge clk); #1;
    nRESET = 1'b1;
    nValid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) nValid++;
    end
    checkOutput("no output after reset release", nValid, 32'd0);
    checkOutput("queue flushed", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
